// File: rtl/spike_cfg_loader.sv
// Boot-time SPI mode-0 master: walks a config ROM and sends one {index, data} frame per entry, MSB first.
// All outputs are registered; abort or reset releases the bus (lnss high, lsck/lmosi low) and returns to idle.
module spike_cfg_loader #(
  parameter int NWORDS = 256,
  parameter int AW     = 8,
  parameter int DW     = 16,
  parameter int SCKDIV = 4
) (
  input  logic             clk10M,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [AW-1:0]    rom_addr,
  input  logic [DW-1:0]    rom_data,
  output logic             lsck,
  output logic             lmosi,
  output logic             lnss,
  input  logic             lmiso,
  output logic [AW+DW-1:0] rx_word,
  output logic             busy,
  output logic             done
);
  localparam int FW = AW + DW;
  localparam int CW = $clog2(2 * SCKDIV);
  localparam int BW = $clog2(FW);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LOAD, S_SETUP, S_SCK_LO, S_SCK_HI, S_HOLD, S_GAP, S_DONE
  } state_t;

  state_t        r_state, w_nxt;
  logic [CW-1:0] r_cnt, w_len;
  logic [BW-1:0] r_bit;
  logic [FW-1:0] r_tx, r_rx, r_rx_word, w_rx_nxt;
  logic [AW-1:0] r_addr;
  logic          r_lsck, r_lmosi, r_lnss, r_busy, r_done;
  logic          w_phase_end, w_sample, w_frame_active;

  assign w_phase_end    = (r_cnt == '0);
  // lmiso is captured in the first cycle lsck is high
  assign w_sample       = (r_state == S_SCK_HI) && (r_cnt == CW'(SCKDIV - 1));
  assign w_rx_nxt       = w_sample ? {r_rx[FW-2:0], lmiso} : r_rx;
  assign w_frame_active = (w_nxt == S_SETUP) || (w_nxt == S_SCK_LO) ||
                          (w_nxt == S_SCK_HI) || (w_nxt == S_HOLD);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_nxt = S_FETCH;
      S_FETCH:  w_nxt = S_LOAD;
      S_LOAD:   w_nxt = S_SETUP;
      S_SETUP:  if (w_phase_end) w_nxt = S_SCK_LO;
      S_SCK_LO: if (w_phase_end) w_nxt = S_SCK_HI;
      S_SCK_HI: if (w_phase_end) w_nxt = (r_bit == BW'(FW - 1)) ? S_HOLD : S_SCK_LO;
      S_HOLD:   if (w_phase_end) w_nxt = S_GAP;
      S_GAP:    if (w_phase_end) w_nxt = (r_addr == AW'(NWORDS - 1)) ? S_DONE : S_FETCH;
      S_DONE:   w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
    if (abort) w_nxt = S_IDLE;
  end

  always_comb begin
    w_len = '0;
    case (w_nxt)
      S_SETUP, S_SCK_LO, S_SCK_HI, S_HOLD: w_len = CW'(SCKDIV - 1);
      S_GAP:                               w_len = CW'(2 * SCKDIV - 1);
      default:                             w_len = '0;
    endcase
  end

  always_ff @(posedge clk10M or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_word <= '0;
      r_addr    <= '0;
      r_lsck    <= 1'b0;
      r_lmosi   <= 1'b0;
      r_lnss    <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_nxt != r_state)  r_cnt <= w_len;
      else if (!w_phase_end) r_cnt <= r_cnt - 1'b1;
      r_rx <= w_rx_nxt;

      if (r_state == S_IDLE && w_nxt == S_FETCH)     r_addr <= '0;
      else if (r_state == S_GAP && w_nxt == S_FETCH) r_addr <= r_addr + 1'b1;

      if (r_state == S_LOAD && w_nxt == S_SETUP) begin
        r_tx  <= {r_addr, rom_data};
        r_bit <= '0;
      end else if (r_state == S_SCK_HI && w_nxt == S_SCK_LO) begin
        r_tx  <= {r_tx[FW-2:0], 1'b0};
        r_bit <= r_bit + 1'b1;
      end

      if (r_state == S_SCK_HI && w_nxt == S_HOLD) r_rx_word <= w_rx_nxt;

      // outputs follow the next state so they are valid the cycle the state is entered
      r_lsck <= (w_nxt == S_SCK_HI);
      r_lnss <= !w_frame_active;
      r_busy <= (w_nxt != S_IDLE) && (w_nxt != S_DONE);
      r_done <= (w_nxt == S_DONE);
      if (w_nxt == S_IDLE)                                 r_lmosi <= 1'b0;
      else if (r_state == S_LOAD && w_nxt == S_SETUP)      r_lmosi <= r_addr[AW-1];
      else if (r_state == S_SCK_HI && w_nxt == S_SCK_LO)   r_lmosi <= r_tx[FW-2];
    end
  end

  assign rom_addr = r_addr;
  assign lsck     = r_lsck;
  assign lmosi    = r_lmosi;
  assign lnss     = r_lnss;
  assign rx_word  = r_rx_word;
  assign busy     = r_busy;
  assign done     = r_done;
endmodule
